cursor_overlay: RTL



---
 rtl/cursor_overlay_pkg.sv | 42 ++++
 rtl/cursor_overlay_blink_timer.sv | 31 +++
 rtl/cursor_overlay.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cursor_overlay_pkg.sv
// Shared definitions for the cursor overlay: host register map, register
// reset defaults and the colour nibble bit order used on fgIn/bgIn.
package cursor_overlay_pkg;

  // Host register addresses
  localparam logic [1:0] CUR_ADDR_COL  = 2'd0;
  localparam logic [1:0] CUR_ADDR_ROW  = 2'd1;
  localparam logic [1:0] CUR_ADDR_CTRL = 2'd2;
  localparam logic [1:0] CUR_ADDR_END  = 2'd3;

  // Reset defaults that do not depend on the cell height
  localparam logic [6:0] CUR_DEF_COL = 7'd0;
  localparam logic [4:0] CUR_DEF_ROW = 5'd0;
  localparam logic       CUR_DEF_EN  = 1'b1;

  // Colour nibble bit order {R,G,B,I}
  localparam int CLR_R = 3;
  localparam int CLR_G = 2;
  localparam int CLR_B = 1;
  localparam int CLR_I = 0;

  // One complete set of cursor position/shape registers
  typedef struct packed {
    logic [6:0] col;
    logic [4:0] row;
    logic       en;
    logic [3:0] startLine;
    logic [3:0] endLine;
  } cursorRegs_t;

  // Default register set: an underline on the last two scanlines of the cell
  function automatic cursorRegs_t cursorDefaults(input int charH);
    cursorRegs_t r;
    r.col       = CUR_DEF_COL;
    r.row       = CUR_DEF_ROW;
    r.en        = CUR_DEF_EN;
    r.startLine = 4'(charH - 2);
    r.endLine   = 4'(charH - 1);
    return r;
  endfunction

endpackage

// File: rtl/cursor_overlay_blink_timer.sv
// Blink timer for the cursor overlay: counts frames and toggles blinkOn
// every BLINK_FRAMES frames. Only instanced when CURSOR_BLINK_EN is defined.
module blink_timer #(
  parameter int BLINK_FRAMES = 16
) (
  input  logic clk,
  input  logic nrst,
  input  logic frameTick,
  output logic blinkOn
);

  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0] frameCount;

  // Count frames 0..BLINK_FRAMES-1 and flip the blink phase on each wrap
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      frameCount <= '0;
      blinkOn    <= 1'b1;
    end else if (frameTick) begin
      if (frameCount == CW'(BLINK_FRAMES - 1)) begin
        frameCount <= '0;
        blinkOn    <= ~blinkOn;
      end else begin
        frameCount <= frameCount + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cursor_overlay.sv
// Hardware text cursor overlay between pixgen and vga_output.
// Tracks the character cell from nVis/vSync timing, holds host-written
// cursor registers (shadowed, applied at frame start) and inverts the glyph
// pixel inside the cursor cell. All pass-through signals are delayed 1 clk.
// Build option: define CURSOR_BLINK_EN to make the cursor blink; otherwise
// the cursor is steady.
module cursor_overlay
  import cursor_overlay_pkg::*;
#(
  parameter int   COLS         = 80,
  parameter int   ROWS         = 30,
  parameter int   CHAR_W       = 8,
  parameter int   CHAR_H       = 16,
  parameter int   BLINK_FRAMES = 16,
  parameter logic VSYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       pixelIn,
  input  logic [3:0] fgIn,
  input  logic [3:0] bgIn,
  input  logic       nVisIn,
  input  logic       hSyncIn,
  input  logic       vSyncIn,
  input  logic       curWr,
  input  logic [1:0] curAddr,
  input  logic [7:0] curWrData,
  output logic       pixelOut,
  output logic [3:0] fgOut,
  output logic [3:0] bgOut,
  output logic       nVisOut,
  output logic       hSyncOut,
  output logic       vSyncOut
);

  localparam int          PW         = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;
  localparam cursorRegs_t RESET_REGS = cursorDefaults(CHAR_H);

  cursorRegs_t   shadowRegs;
  cursorRegs_t   liveRegs;
  logic [PW-1:0] pxInCell;
  logic [6:0]    charCol;
  logic [3:0]    lineInCell;
  logic [4:0]    charRow;
  logic          frameStart;
  logic          lineEnd;
  logic          blinkOn;
  logic          hit;

  // The registered copies of vSyncIn/nVisIn double as the previous samples
  assign frameStart = (vSyncIn == VSYNC_ACTIVE) && (vSyncOut != VSYNC_ACTIVE);
  assign lineEnd    = nVisIn && !nVisOut;

`ifdef CURSOR_BLINK_EN
  blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) uBlinkTimer (
    .clk      (clk),
    .nrst     (nrst),
    .frameTick(frameStart),
    .blinkOn  (blinkOn)
  );
`else
  // Steady cursor; the comparison only keeps BLINK_FRAMES referenced in this build
  assign blinkOn = (BLINK_FRAMES >= 0) || 1'b1;
`endif

  // Host writes land in the shadow set; unused data bits are dropped
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      shadowRegs <= RESET_REGS;
    end else if (curWr) begin
      case (curAddr)
        CUR_ADDR_COL:  shadowRegs.col <= curWrData[6:0];
        CUR_ADDR_ROW:  shadowRegs.row <= curWrData[4:0];
        CUR_ADDR_CTRL: begin
          shadowRegs.en        <= curWrData[7];
          shadowRegs.startLine <= curWrData[3:0];
        end
        default:       shadowRegs.endLine <= curWrData[3:0];
      endcase
    end
  end

  // Live set only changes at frame start so the cursor never tears mid-frame
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      liveRegs <= RESET_REGS;
    end else if (frameStart) begin
      liveRegs <= shadowRegs;
    end
  end

  // Horizontal cell position, cleared whenever the pixel is not visible
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pxInCell <= '0;
      charCol  <= '0;
    end else if (nVisIn) begin
      pxInCell <= '0;
      charCol  <= '0;
    end else if (pxInCell == PW'(CHAR_W - 1)) begin
      pxInCell <= '0;
      charCol  <= charCol + 7'd1;
    end else begin
      pxInCell <= pxInCell + 1'b1;
    end
  end

  // Vertical cell position: advance per visible line, restart at frame start
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      lineInCell <= '0;
      charRow    <= '0;
    end else if (frameStart) begin
      lineInCell <= '0;
      charRow    <= '0;
    end else if (lineEnd) begin
      if (lineInCell == 4'(CHAR_H - 1)) begin
        lineInCell <= '0;
        if (charRow < 5'(ROWS)) begin
          charRow <= charRow + 5'd1;
        end
      end else begin
        lineInCell <= lineInCell + 4'd1;
      end
    end
  end

  // Cursor hit for the pixel currently on the input
  always_comb begin
    hit = 1'b0;
    if (!nVisIn && liveRegs.en && blinkOn &&
        (liveRegs.col < 7'(COLS)) && (liveRegs.row < 5'(ROWS)) &&
        (charCol == liveRegs.col) && (charRow == liveRegs.row) &&
        (liveRegs.startLine <= lineInCell) && (lineInCell <= liveRegs.endLine)) begin
      hit = 1'b1;
    end
  end

  // Output stage: one register on every path keeps colour, pixel and sync aligned
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pixelOut <= 1'b0;
      fgOut    <= 4'd0;
      bgOut    <= 4'd0;
      nVisOut  <= 1'b1;
      hSyncOut <= 1'b1;
      vSyncOut <= ~VSYNC_ACTIVE;
    end else begin
      pixelOut <= pixelIn ^ hit;
      fgOut    <= fgIn;
      bgOut    <= bgIn;
      nVisOut  <= nVisIn;
      hSyncOut <= hSyncIn;
      vSyncOut <= vSyncIn;
    end
  end

endmodule
